// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 driver: FSM state encoding, default
// frame geometry and a width helper.
package hc595_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    CLEAR    = 3'd3,
    LATCH    = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 2;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hc595_phase_tick.sv
// Phase timer: counts DIV system clocks and strobes phase_end on the last one,
// restarting from zero whenever restart is held.
module hc595_phase_tick
  import hc595_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase_end
);

  localparam int CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hc595_driver.sv
// Sequences a 74HC595 shift/latch register: serializes a parallel word with
// generated shift clocks, pulses the latch, and owns the clear and OE pins.
module hc595_driver
  import hc595_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  input  logic             clr,
  input  logic             oe_en,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             srclr_n,
  output logic             oe_n,
  output logic             busy,
  output logic             done
);

  localparam int BW = clog2_min1(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BW-1:0]    bit_cnt;
  logic             phase_end;
  logic             restart;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign ready      = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = valid && ready && !clr;
  assign restart    = (state == IDLE) || (state == FIN);
  assign shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  hc595_phase_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .phase_end (phase_end)
  );

  // SER changes only together with the falling SRCLK edge, so it is stable a
  // full phase before each rising edge and throughout the high phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ser     <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      srclr_n <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          srclr_n <= 1'b1;
          if (clr) begin
            srclr_n <= 1'b0;
            state   <= CLEAR;
          end else if (accept) begin
            shreg   <= data;
            bit_cnt <= '0;
            ser     <= head(data);
            srclk   <= 1'b0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            srclk <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            srclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              ser   <= 1'b0;
              rclk  <= 1'b1;
              state <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg_next;
              ser     <= head(shreg_next);
              state   <= SHIFT_LO;
            end
          end
        end
        CLEAR: begin
          if (phase_end) begin
            srclr_n <= 1'b1;
            rclk    <= 1'b1;
            state   <= LATCH;
          end
        end
        LATCH: begin
          if (phase_end) begin
            rclk  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_n <= 1'b1;
    end else begin
      oe_n <= ~oe_en;
    end
  end

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench: two drivers (MSB-first and LSB-first) each driving a
// behavioural 74HC595 model, checked against hand-computed frame timing.
module tb_hc595_driver;

  logic       clk;
  logic       rst_n;
  logic       oe_en;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, clr_a, clr_b;
  logic       ready_a, ready_b, ser_a, ser_b, srclk_a, srclk_b, rclk_a, rclk_b;
  logic       srclr_n_a, srclr_n_b, oe_n_a, oe_n_b, busy_a, busy_b, done_a, done_b;

  logic [7:0] sr_a, sr_b, q_a, q_b;

  int compared;
  int mismatched;

  int         o_rises, o_first_rise, o_last_rise, o_rclk_first, o_rclk_cnt;
  int         o_done_first, o_done_cnt, o_clr_first, o_clr_cnt;
  logic [31:0] o_bits;
  bit         o_setup_ok, o_busy1, o_ready_last;

  hc595_driver #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data(data_a), .valid(valid_a), .ready(ready_a),
    .clr(clr_a), .oe_en(oe_en), .ser(ser_a), .srclk(srclk_a), .rclk(rclk_a),
    .srclr_n(srclr_n_a), .oe_n(oe_n_a), .busy(busy_a), .done(done_a)
  );

  hc595_driver #(.WIDTH(8), .DIV(2), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .data(data_b), .valid(valid_b), .ready(ready_b),
    .clr(clr_b), .oe_en(oe_en), .ser(ser_b), .srclk(srclk_b), .rclk(rclk_b),
    .srclr_n(srclr_n_b), .oe_n(oe_n_b), .busy(busy_b), .done(done_b)
  );

  // Behavioural 74HC595: A shifts into Qa, Qh is the oldest bit (q[7]).
  always @(posedge srclk_a or negedge srclr_n_a)
    if (!srclr_n_a) sr_a <= 8'h00; else sr_a <= {sr_a[6:0], ser_a};
  always @(posedge rclk_a) q_a <= sr_a;
  always @(posedge srclk_b or negedge srclr_n_b)
    if (!srclr_n_b) sr_b <= 8'h00; else sr_b <= {sr_b[6:0], ser_b};
  always @(posedge rclk_b) q_b <= sr_b;

  always #5 clk = ~clk;

  task automatic start_a(input logic [7:0] d);
    @(negedge clk);
    data_a  = d;
    valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
  endtask

  // Records one frame's pin activity, cycle n=1 being the cycle after accept.
  task automatic observe(input bit sel, input int ncyc);
    logic p_srclk, p_ser, s_srclk, s_ser, s_rclk, s_done, s_clr;
    o_rises = 0; o_bits = '0; o_first_rise = -1; o_last_rise = -1;
    o_rclk_first = -1; o_rclk_cnt = 0; o_done_first = -1; o_done_cnt = 0;
    o_clr_first = -1; o_clr_cnt = 0; o_setup_ok = 1'b1; o_busy1 = 1'b0; o_ready_last = 1'b0;
    p_srclk = 1'b0; p_ser = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      s_srclk = sel ? srclk_b : srclk_a;
      s_ser   = sel ? ser_b : ser_a;
      s_rclk  = sel ? rclk_b : rclk_a;
      s_done  = sel ? done_b : done_a;
      s_clr   = sel ? !srclr_n_b : !srclr_n_a;
      if (n == 1) o_busy1 = sel ? busy_b : busy_a;
      o_ready_last = sel ? ready_b : ready_a;
      if (s_srclk && !p_srclk) begin
        o_rises++;
        o_bits = {o_bits[30:0], s_ser};
        if (o_first_rise < 0) o_first_rise = n;
        o_last_rise = n;
      end
      if (s_srclk && (s_ser !== p_ser)) o_setup_ok = 1'b0;
      if (s_rclk) begin o_rclk_cnt++; if (o_rclk_first < 0) o_rclk_first = n; end
      if (s_done) begin o_done_cnt++; if (o_done_first < 0) o_done_first = n; end
      if (s_clr) begin o_clr_cnt++; if (o_clr_first < 0) o_clr_first = n; end
      p_srclk = s_srclk;
      p_ser   = s_ser;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    compared++; if (srclr_n_a !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_srclr_n: got %b want 0", srclr_n_a); end
    compared++; if (oe_n_a !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_oe_n: got %b want 1", oe_n_a); end
    compared++; if ({srclk_a, rclk_a, ser_a, done_a} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_pins: got %b want 0000", {srclk_a, rclk_a, ser_a, done_a}); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (srclr_n_a !== 1'b1) begin mismatched++; $display("[TB] FAIL rel_srclr_n: got %b want 1", srclr_n_a); end
    compared++; if ({ready_a, busy_a} !== 2'b10) begin mismatched++; $display("[TB] FAIL rel_ready_busy: got %b want 10", {ready_a, busy_a}); end
    compared++; if (oe_n_a !== 1'b0) begin mismatched++; $display("[TB] FAIL rel_oe_n: got %b want 0", oe_n_a); end
  endtask

  task automatic test_msb_frame();
    start_a(8'hA5);
    observe(1'b0, 36);
    compared++; if (o_rises !== 8) begin mismatched++; $display("[TB] FAIL a5_rises: got %0d want 8", o_rises); end
    compared++; if (o_bits[7:0] !== 8'hA5) begin mismatched++; $display("[TB] FAIL a5_ser_bits: got %h want a5", o_bits[7:0]); end
    compared++; if ({o_first_rise, o_last_rise} !== {32'd3, 32'd31}) begin mismatched++; $display("[TB] FAIL a5_rise_cycles: got %0d/%0d want 3/31", o_first_rise, o_last_rise); end
    compared++; if (o_setup_ok !== 1'b1) begin mismatched++; $display("[TB] FAIL a5_ser_setup_hold: got %b want 1", o_setup_ok); end
    compared++; if ({o_rclk_first, o_rclk_cnt} !== {32'd33, 32'd2}) begin mismatched++; $display("[TB] FAIL a5_rclk: got start %0d len %0d want 33/2", o_rclk_first, o_rclk_cnt); end
    compared++; if ({o_done_first, o_done_cnt} !== {32'd35, 32'd1}) begin mismatched++; $display("[TB] FAIL a5_done: got cycle %0d count %0d want 35/1", o_done_first, o_done_cnt); end
    compared++; if (o_ready_last !== 1'b1) begin mismatched++; $display("[TB] FAIL a5_ready_back: got %b want 1", o_ready_last); end
    compared++; if (q_a !== 8'hA5) begin mismatched++; $display("[TB] FAIL a5_q: got %b want 10100101", q_a); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    data_b  = 8'h01;
    valid_b = 1'b1;
    @(posedge clk);
    #1 data_b = 8'h80;
    observe(1'b1, 35);
    compared++; if (o_done_first !== 35) begin mismatched++; $display("[TB] FAIL b2b_done1: got %0d want 35", o_done_first); end
    compared++; if (o_bits[7:0] !== 8'h80) begin mismatched++; $display("[TB] FAIL b2b_bits1: got %h want 80", o_bits[7:0]); end
    compared++; if (q_b !== 8'h80) begin mismatched++; $display("[TB] FAIL b2b_q1: got %b want 10000000", q_b); end
    @(negedge clk);
    compared++; if (ready_b !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready: got %b want 1", ready_b); end
    @(posedge clk);
    #1 valid_b = 1'b0;
    observe(1'b1, 36);
    compared++; if (o_busy1 !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_accept2: got busy %b want 1", o_busy1); end
    compared++; if (o_done_first !== 35) begin mismatched++; $display("[TB] FAIL b2b_done2: got %0d want 35", o_done_first); end
    compared++; if (q_b !== 8'h01) begin mismatched++; $display("[TB] FAIL b2b_q2: got %b want 00000001", q_b); end
  endtask

  task automatic test_clear();
    start_a(8'hFF);
    observe(1'b0, 36);
    compared++; if (q_a !== 8'hFF) begin mismatched++; $display("[TB] FAIL clr_preload_q: got %b want 11111111", q_a); end
    @(negedge clk);
    data_a  = 8'h12;
    valid_a = 1'b1;
    clr_a   = 1'b1;
    @(posedge clk);
    #1 begin valid_a = 1'b0; clr_a = 1'b0; end
    observe(1'b0, 8);
    compared++; if (o_rises !== 0) begin mismatched++; $display("[TB] FAIL clr_no_shift: got %0d rises want 0", o_rises); end
    compared++; if ({o_clr_first, o_clr_cnt} !== {32'd1, 32'd2}) begin mismatched++; $display("[TB] FAIL clr_srclr: got start %0d len %0d want 1/2", o_clr_first, o_clr_cnt); end
    compared++; if ({o_rclk_first, o_rclk_cnt} !== {32'd3, 32'd2}) begin mismatched++; $display("[TB] FAIL clr_rclk: got start %0d len %0d want 3/2", o_rclk_first, o_rclk_cnt); end
    compared++; if ({o_done_first, o_done_cnt} !== {32'd5, 32'd1}) begin mismatched++; $display("[TB] FAIL clr_done: got cycle %0d count %0d want 5/1", o_done_first, o_done_cnt); end
    compared++; if (q_a !== 8'h00) begin mismatched++; $display("[TB] FAIL clr_q: got %b want 00000000", q_a); end
  endtask

  task automatic test_reset_abort();
    int  rises;
    bit  done_seen;
    logic p;
    rises = 0;
    p = 1'b0;
    start_a(8'hF0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (srclk_a && !p) rises++;
      p = srclk_a;
      if (rises == 4) break;
    end
    compared++; if (rises !== 4) begin mismatched++; $display("[TB] FAIL abort_reach: got %0d rises want 4", rises); end
    rst_n = 1'b0;
    #1;
    compared++; if ({ser_a, srclk_a, rclk_a, srclr_n_a, oe_n_a, busy_a} !== 6'b000010) begin mismatched++; $display("[TB] FAIL abort_pins: got %b want 000010", {ser_a, srclk_a, rclk_a, srclr_n_a, oe_n_a, busy_a}); end
    done_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (done_a) done_seen = 1'b1; end
    compared++; if (done_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_no_done: got %b want 0", done_seen); end
    compared++; if (q_a !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_q_hold: got %b want 00000000", q_a); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (srclr_n_a !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_rel_srclr: got %b want 1", srclr_n_a); end
    start_a(8'h3C);
    observe(1'b0, 36);
    compared++; if (o_done_first !== 35) begin mismatched++; $display("[TB] FAIL abort_3c_done: got %0d want 35", o_done_first); end
    compared++; if (q_a !== 8'h3C) begin mismatched++; $display("[TB] FAIL abort_3c_q: got %b want 00111100", q_a); end
  endtask

  task automatic test_oe();
    int   rises;
    int   done_first;
    logic p;
    logic oe10, oe11, oe20, oe21;
    rises = 0; done_first = -1; p = 1'b0;
    oe10 = 1'bx; oe11 = 1'bx; oe20 = 1'bx; oe21 = 1'bx;
    start_a(8'h5A);
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (srclk_a && !p) rises++;
      p = srclk_a;
      if (done_a && done_first < 0) done_first = n;
      if (n == 10) begin oe10 = oe_n_a; oe_en = 1'b0; end
      if (n == 11) oe11 = oe_n_a;
      if (n == 20) begin oe20 = oe_n_a; oe_en = 1'b1; end
      if (n == 21) oe21 = oe_n_a;
    end
    compared++; if ({oe10, oe11} !== 2'b01) begin mismatched++; $display("[TB] FAIL oe_off_latency: got %b want 01", {oe10, oe11}); end
    compared++; if ({oe20, oe21} !== 2'b10) begin mismatched++; $display("[TB] FAIL oe_on_latency: got %b want 10", {oe20, oe21}); end
    compared++; if ({rises, done_first} !== {32'd8, 32'd35}) begin mismatched++; $display("[TB] FAIL oe_timing: got rises %0d done %0d want 8/35", rises, done_first); end
    compared++; if (q_a !== 8'h5A) begin mismatched++; $display("[TB] FAIL oe_q: got %b want 01011010", q_a); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clk     = 1'b0;
    rst_n   = 1'b1;
    oe_en   = 1'b1;
    data_a  = 8'h00; data_b  = 8'h00;
    valid_a = 1'b0;  valid_b = 1'b0;
    clr_a   = 1'b0;  clr_b   = 1'b0;
    test_reset();
    test_msb_frame();
    test_back_to_back();
    test_clear();
    test_reset_abort();
    test_oe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hc595_driver.md
# hc595_driver

Synchronous controller that sequences a 74HC595-class shift/latch register (the `top` model) from a single system clock. It accepts a parallel word over a VALID/READY handshake and serializes it onto the serial data input with generated shift-clock pulses. It then pulses the latch clock and signals completion. It also owns the register's clear line and output-enable line, so it sits directly between a parallel producer and the `top` pins A, SHIFTCLOCK, LATCHCLOCK, RESET and OUTPUTENABLE.

## Interface
- WIDTH, 8 — bits per frame (chain length); must be ≥1.
- DIV, 2 — system-clock cycles per SHIFTCLOCK/LATCHCLOCK phase; must be ≥1.
- MSB_FIRST, 1 — 1: DATA[WIDTH-1] is shifted first; 0: DATA[0] is shifted first.

- CLOCK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DATA  in  WIDTH  parallel word, sampled on accept.
- VALID  in  1  producer has a word.
- READY  out  1  high in IDLE.
- CLR  in  1  clear request, sampled in IDLE.
- OE_EN  in  1  1 enables the register outputs.
- SER  out  1  drives A.
- SRCLK  out  1  drives SHIFTCLOCK.
- RCLK  out  1  drives LATCHCLOCK.
- SRCLR_N  out  1  drives the register RESET (active-low).
- OE_N  out  1  drives OUTPUTENABLE (active-low).
- BUSY  out  1  state ≠ IDLE.
- DONE  out  1  one-cycle completion strobe.

## Operation
- All outputs are registered except READY and BUSY, which are decoded from the state register.
- Reset values: SER=0, SRCLK=0, RCLK=0, SRCLR_N=0, OE_N=1, DONE=0; state is IDLE.
- SRCLR_N rises on the first CLOCK edge after RESET deasserts, so the register stays cleared for the whole of reset.
- OE_N = ~OE_EN, registered with one cycle of latency and independent of state.
- States: IDLE, SHIFT_LO, SHIFT_HI, CLEAR, LATCH, FIN.
- IDLE:
  - CLR=1 → CLEAR. CLR has priority: a transfer happens only when VALID & READY & ~CLR.
  - Transfer → capture DATA into the shift buffer, reset bit counter to 0, go to SHIFT_LO.
- SHIFT_LO: SER = current bit, SRCLK=0, held DIV cycles → SHIFT_HI.
- SHIFT_HI: SRCLK=1 and SER held, DIV cycles.
  - Bit counter = WIDTH-1 → LATCH.
  - Otherwise → increment the counter and return to SHIFT_LO.
- CLEAR: SRCLR_N=0 for DIV cycles → LATCH, so zeros are transferred to the outputs.
- LATCH: RCLK=1 for DIV cycles, SRCLK=0 → FIN.
- FIN: RCLK=0, DONE=1 for one cycle → IDLE.
- DATA, VALID and CLR are ignored outside IDLE; CLR is not queued.
- SER returns to 0 in LATCH/FIN/IDLE.
- Bit counter width is $clog2(WIDTH) with a minimum of 1. The phase counter counts 0..DIV-1 and rolls over at each phase end.
- RESET mid-frame aborts immediately: all outputs return to reset values, no DONE, and the register is cleared via SRCLR_N.

## Timing
- Accept at edge t (VALID & READY & ~CLR sampled):
  - SHIFT_LO for bit 0 occupies cycles t+1..t+DIV.
  - Bit k SRCLK rising edge is at cycle t+1+(2k+1)·DIV.
- RCLK is high for cycles t+1+2·DIV·WIDTH .. t+2·DIV·WIDTH+DIV.
- DONE is at cycle t+1+2·DIV·WIDTH+DIV; READY returns the following cycle.
- Clear frame: SRCLR_N low for DIV cycles, RCLK high for DIV cycles, DONE at t+1+2·DIV.
- SER is stable DIV cycles before and throughout every SRCLK high phase (setup/hold ≥ DIV cycles).
- Back-to-back: if VALID is held high, the next accept occurs on the cycle READY returns. Throughput is one word per 2·DIV·WIDTH+DIV+2 cycles.

## Structure
- Shared package/include `hc595_pkg` contains:
  - state encoding constants (IDLE..FIN)
  - default WIDTH/DIV
  - a clog2 helper
- Natural sub-module: `hc595_phase_tick`, a DIV-cycle phase counter with a synchronous restart input and a one-cycle `phase_end` strobe. The FSM advances only on `phase_end`.
- Top-level `hc595_driver` holds the FSM, shift buffer, bit counter and output registers. The bench instantiates it driving `top`.

## Test plan
- Reset held 5 cycles → SRCLR_N=0, OE_N=1, SRCLK=RCLK=SER=0 during reset; SRCLR_N=1 one cycle after release; READY=1.
- DIV=2, WIDTH=8, MSB_FIRST=1, send 0xA5 → SER per bit 1,0,1,0,0,1,0,1; 8 SRCLK rises; one RCLK pulse of 2 cycles; DONE 35 cycles after accept; with OE_EN=1, `top` Qh..Qa = 10100101.
- MSB_FIRST=0, send 0x01, then 0x80 back-to-back with VALID held → second accept exactly 1 cycle after DONE; final Qh..Qa = 00000001.
- Load 0xFF, then CLR=1 together with VALID=1 in IDLE → no transfer; SRCLR_N low 2 cycles, RCLK pulse, DONE at accept+5; Qh..Qa = 00000000.
- Assert RESET low after the 4th SRCLK rise of a 0xF0 frame → outputs at reset values, no DONE; after release send 0x3C → Qh..Qa = 00111100.
- Toggle OE_EN mid-frame → OE_N follows with 1-cycle latency; shift timing and DONE cycle unchanged.
